// File: rtl/life_sequencer_if.sv
// Control/handshake bundle between the life_sequencer, its seed source and the cell datapath.
// master = sequencer side (drives datapath controls and status), slave = environment side.
interface life_sequencer_if #(
    parameter int GEN_W = 5,
    parameter int IDX_W = 4
);
    logic                   start;
    logic [GEN_W-1:0]       gen_limit;
    logic                   cell_valid;
    logic                   cell_bit;
    logic                   cell_ready;
    logic                   loseSig;
    logic                   loadData;
    logic                   readData;
    logic                   writeData;
    logic                   writeout;
    logic                   DataIn;
    logic [IDX_W+GEN_W-1:0] count;
    logic                   busy;
    logic                   done;
    logic                   lost;

    modport master (
        input  start, gen_limit, cell_valid, cell_bit, loseSig,
        output cell_ready, loadData, readData, writeData, writeout, DataIn,
               count, busy, done, lost
    );

    modport slave (
        output start, gen_limit, cell_valid, cell_bit, loseSig,
        input  cell_ready, loadData, readData, writeData, writeout, DataIn,
               count, busy, done, lost
    );
endinterface

// File: rtl/life_sequencer.sv
// Game-of-Life datapath sequencer: seed load, N x (16-cell eval, settle, writeout); LIFE_SEQ_LOSE_EN enables extinction abort.
// Outputs registered, strobe one cycle after decision; seed port stalls freely (cell_ready held high through LOAD).
module life_sequencer #(
    parameter int CELLS = 16,
    parameter int GEN_W = 5
) (
    input  logic              clka,
    input  logic              restart,
    life_sequencer_if.master  bus
);
    localparam int IDX_W = $clog2(CELLS);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SETTLE = 3'd2,
        XFER   = 3'd3,
        EVAL   = 3'd4,
        DONE   = 3'd5,
        LOST   = 3'd6
    } state_t;

    typedef struct packed {
        logic                   cell_ready;
        logic                   loadData;
        logic                   readData;
        logic                   writeData;
        logic                   writeout;
        logic                   DataIn;
        logic [IDX_W+GEN_W-1:0] count;
        logic                   busy;
        logic                   done;
        logic                   lost;
    } ctl_t;

    state_t           r_state, w_state_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    logic [GEN_W-1:0] r_gen, w_gen_nxt;
    logic [GEN_W-1:0] r_limit, w_limit_nxt;
    logic [GEN_W-1:0] w_gen_inc;
    logic             r_load_flag, w_load_flag_nxt;
    logic             w_hs;
    ctl_t             r_out, w_out;

    always_ff @(posedge clka or negedge restart) begin
        if (!restart) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_gen       <= '0;
            r_limit     <= '0;
            r_load_flag <= 1'b0;
            r_out       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_gen       <= w_gen_nxt;
            r_limit     <= w_limit_nxt;
            r_load_flag <= w_load_flag_nxt;
            r_out       <= w_out;
        end
    end

    assign w_hs      = (r_state == LOAD) && r_out.cell_ready && bus.cell_valid;
    assign w_gen_inc = r_gen + GEN_W'(1);

    // w_out is what the datapath sees during the cycle after this one.
    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_gen_nxt       = r_gen;
        w_limit_nxt     = r_limit;
        w_load_flag_nxt = r_load_flag;
        w_out           = '0;
        w_out.count     = r_out.count;

        unique case (r_state)
            IDLE, DONE, LOST: begin
                w_out.done = (r_state == DONE);
`ifdef LIFE_SEQ_LOSE_EN
                w_out.lost = (r_state == LOST);
`endif
                if (bus.start) begin
                    w_state_nxt      = LOAD;
                    w_limit_nxt      = bus.gen_limit;
                    w_gen_nxt        = '0;
                    w_idx_nxt        = '0;
                    w_load_flag_nxt  = 1'b1;
                    w_out.done       = 1'b0;
                    w_out.lost       = 1'b0;
                    w_out.busy       = 1'b1;
                    w_out.cell_ready = 1'b1;
                end
            end

            LOAD: begin
                w_out.busy       = 1'b1;
                w_out.cell_ready = 1'b1;
                if (w_hs) begin
                    w_out.loadData  = 1'b1;
                    w_out.writeData = 1'b1;
                    w_out.DataIn    = bus.cell_bit;
                    w_out.count     = {r_gen, r_idx};
                    w_idx_nxt       = r_idx + IDX_W'(1);
                    if (r_idx == IDX_W'(CELLS - 1)) begin
                        w_state_nxt      = SETTLE;
                        w_out.cell_ready = 1'b0;
                    end
                end
            end

            SETTLE: begin
                w_out.busy  = 1'b1;
                w_state_nxt = XFER;
            end

            XFER: begin
                w_out.busy     = 1'b1;
                w_out.writeout = 1'b1;
                if (r_load_flag) begin
                    w_load_flag_nxt = 1'b0;
                    w_state_nxt     = (r_limit == '0) ? DONE : EVAL;
                end else begin
                    w_gen_nxt   = w_gen_inc;
                    w_state_nxt = (w_gen_inc == r_limit) ? DONE : EVAL;
`ifdef LIFE_SEQ_LOSE_EN
                    // Extinction wins even when the limit is reached on this transfer.
                    if (bus.loseSig) begin
                        w_state_nxt = LOST;
                    end
`endif
                end
            end

            EVAL: begin
                w_out.busy      = 1'b1;
                w_out.readData  = 1'b1;
                w_out.writeData = 1'b1;
                w_out.count     = {r_gen, r_idx};
                w_idx_nxt       = r_idx + IDX_W'(1);
                if (r_idx == IDX_W'(CELLS - 1)) begin
                    w_state_nxt = SETTLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

`ifndef LIFE_SEQ_LOSE_EN
    logic w_unused_lose;
    assign w_unused_lose = bus.loseSig;
`endif

    assign bus.cell_ready = r_out.cell_ready;
    assign bus.loadData   = r_out.loadData;
    assign bus.readData   = r_out.readData;
    assign bus.writeData  = r_out.writeData;
    assign bus.writeout   = r_out.writeout;
    assign bus.DataIn     = r_out.DataIn;
    assign bus.count      = r_out.count;
    assign bus.busy       = r_out.busy;
    assign bus.done       = r_out.done;
    assign bus.lost       = r_out.lost;
endmodule

// File: doc/life_sequencer.md
# life_sequencer

Control sequencer that sits directly upstream of the Game-of-Life cell datapath and drives its control inputs. It accepts a 16-cell seed board through a valid/ready serial port and steps the datapath through load, evaluate and write-out phases for a programmable number of generations. It then reports completion, or an early extinction when the datapath raises `loseSig`.

## Interface
Parameters:
- `CELLS`, 16: cells per board; fixed 4x4 torus; cell index is 4 bits.
- `GEN_W`, 5: generation counter width; `CELLS` index width + `GEN_W` = 9 = `count` width.

Ports:
- `clka`  in  1  sole clock, rising edge.
- `restart`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a run; honoured in IDLE, DONE and LOST only.
- `gen_limit`  in  5  generations to compute; sampled on accepted `start`.
- `cell_valid`  in  1  seed bit present on `cell_bit`.
- `cell_bit`  in  1  seed cell value; cells arrive in index order 0..15.
- `cell_ready`  out  1  sequencer accepts a seed bit this cycle.
- `loseSig`  in  1  extinction flag from the datapath.
- `loadData`  out  1  datapath: write `DataIn` into cell `count[3:0]`.
- `readData`  out  1  datapath: evaluate cell `count[3:0]`.
- `writeData`  out  1  datapath write enable; qualifies `loadData`/`readData`.
- `writeout`  out  1  datapath: commit next board to the current board.
- `DataIn`  out  1  registered seed bit.
- `count`  out  9  `[3:0]` cell index, `[8:4]` generation number.
- `busy`  out  1  run in progress.
- `done`  out  1  run completed `gen_limit` generations.
- `lost`  out  1  run aborted by extinction.

## Operation
- States: IDLE, LOAD, SETTLE, XFER, EVAL, DONE, LOST.
- All outputs are registered. Reset value of every output is 0; reset mid-run returns to IDLE and clears the cell index, the generation count and the load flag.
- IDLE: all strobes 0, `cell_ready`=0. Accepted `start` latches `gen_limit`, clears the generation count, sets the load flag and moves to LOAD.
- LOAD: `cell_ready`=1.
  - Each handshake (`cell_valid`&`cell_ready`) drives `loadData`=`writeData`=1, `DataIn`=`cell_bit` and `count[3:0]`=index for exactly the next cycle. The index then increments.
  - Cycles without a handshake drive strobes 0.
  - On the 16th handshake the state moves to SETTLE, and `cell_ready` drops the following cycle.
- SETTLE: one cycle with all strobes 0, so the datapath captures the next board. Then XFER.
- XFER: `writeout`=1 for one cycle.
  - If the load flag is set: clear the flag. Go to DONE if the latched limit is 0, otherwise go to EVAL.
  - If the load flag is clear: the generation count increments (5-bit, wraps 31→0). Go to DONE if the new count equals the latched limit, otherwise go to EVAL.
- EVAL: 16 consecutive cycles with `readData`=`writeData`=1 and `count[3:0]`=0..15, `count[8:4]`=the current generation. After index 15, go to SETTLE.
- DONE: `done`=1, `busy`=0, strobes 0. Held until an accepted `start`, which clears `done` and enters LOAD.
- LOST: same behaviour as DONE, with `lost`=1.
- `busy`=1 in LOAD, SETTLE, XFER and EVAL.
- `start` while busy is ignored.
- `cell_valid` outside LOAD is ignored.

## Timing
- `start` at edge N: `busy`=`cell_ready`=1 after edge N+1.
- Load strobe latency: handshake at edge M → `loadData` high in the cycle after edge M.
- Minimum load phase: 16 cycles, then 1 SETTLE cycle and 1 XFER cycle.
- Each generation: 16 EVAL cycles, then 1 SETTLE cycle and 1 XFER cycle (18 cycles total).
- Minimum total run time with no stalls: 18 + 18·`gen_limit` cycles.
- `done`/`lost` rises the cycle after the final XFER.

## Configuration
- `LIFE_SEQ_LOSE_EN` defined:
  - `loseSig` is sampled during XFER when the load flag is clear.
  - If it is 1, the state moves to LOST instead of EVAL or DONE. `lost` takes priority if the limit is reached in the same XFER.
- Undefined: `loseSig` is ignored and `lost` is tied to 0.

## Test plan
- Reset mid-EVAL (`restart`=0 at arbitrary edge) → all outputs 0 immediately, state IDLE; next `start` restarts from cell 0.
- `start`, `gen_limit`=0, 16 seed bits 1010… with `cell_valid` held high → `loadData` pulses 16 cycles with `count`=0..15 and `DataIn` matching the seed. Then 1 SETTLE cycle, 1 `writeout` pulse, then `done`=1.
- `gen_limit`=2, no stalls → exactly 2 EVAL sweeps with `count[8:4]`=0 then 1, 3 `writeout` pulses total, `done` at cycle 54 after `start`.
- Seed with `cell_valid` toggled every other cycle → `cell_ready` stays high, exactly 16 `loadData` pulses, indices contiguous, no strobe on idle cycles.
- With `LIFE_SEQ_LOSE_EN`: `gen_limit`=5, `loseSig`=1 from generation 2 → `lost`=1 after the 2nd generation's XFER, `done`=0, no further EVAL. Without the macro: the same stimulus reaches `done` after 5 generations.
- `start` pulsed during EVAL and with `gen_limit` changed → ignored; the run completes with the original limit.
